// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Reserved size, odd half address, or non-word-aligned word address.
    function automatic logic is_misaligned(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = lo[0];
            SZ_WORD: is_misaligned = (lo != 2'b00);
            default: is_misaligned = 1'b1;
        endcase
    endfunction

    // Byte-lane write enables for an aligned access.
    function automatic logic [3:0] lane_be(input size_e sz, input logic [1:0] lo);
        case (sz)
            SZ_BYTE: lane_be = 4'b0001 << lo;
            SZ_HALF: lane_be = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_be = 4'b1111;
            default: lane_be = 4'b0000;
        endcase
    endfunction

    // Replicate right-justified store data into every lane; the enables pick the lane.
    function automatic logic [31:0] lane_wdata(input size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: lane_wdata = {4{wd[7:0]}};
            SZ_HALF: lane_wdata = {2{wd[15:0]}};
            default: lane_wdata = wd;
        endcase
    endfunction

    // Shift the selected lane down to bit 0, zero-filling above it.
    function automatic logic [31:0] lane_rdata(input size_e sz, input logic [1:0] lo,
                                               input logic [31:0] word);
        case (sz)
            SZ_BYTE: lane_rdata = {24'b0, word[{lo, 3'b000} +: 8]};
            SZ_HALF: lane_rdata = {16'b0, (lo[1] ? word[31:16] : word[15:0])};
            default: lane_rdata = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake between the memory stage and the responder.
interface dmem_responder_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              stall;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/dmem_bank.sv
// Single-port word RAM: byte-lane write enables, registered-address read.
module dmem_bank #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0]   mem [2**AW];
    logic [AW-1:0] addr_q;

    // Write enabled lanes and capture the read address; contents survive reset.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        addr_q <= addr;
    end

    assign rdata = mem[addr_q];
endmodule

// File: rtl/dmem_responder.sv
// Handshaked multi-cycle data-memory slave with wait states, lanes and stall.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);
    localparam int WORD_W = ADDR_W - 2;

    state_e                state;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                  lat_we;
    logic [ADDR_W-1:0]     lat_addr;
    size_e                 lat_size;
    logic [31:0]           lat_wdata;

    logic [WORD_W-1:0]     bank_addr;
    logic [3:0]            bank_we;
    logic [31:0]           bank_wdata;
    logic [31:0]           bank_rdata;
    logic                  access;

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.stall     = ((state == ST_IDLE) && bus.req_valid) || (state == ST_WAIT);

    // The bank registers its read address, so while idle it is fed straight from the
    // request; that lets a zero-wait load see its data one edge after acceptance.
    assign bank_addr  = (state == ST_IDLE) ? bus.req_addr[ADDR_W-1:2] : lat_addr[ADDR_W-1:2];
    assign access     = (state == ST_WAIT) && (cnt == '0);
    assign bank_we    = lane_be(lat_size, lat_addr[1:0]) & {4{access & lat_we}};
    assign bank_wdata = lane_wdata(lat_size, lat_wdata);

    dmem_bank #(.AW(WORD_W)) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    // Request FSM with wait counter and registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_size      <= SZ_BYTE;
            lat_wdata     <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_size  <= size_e'(bus.req_size);
                        lat_wdata <= bus.req_wdata;
                        if (is_misaligned(size_e'(bus.req_size), bus.req_addr[1:0])) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b1;
                            bus.rsp_rdata <= '0;
                            state         <= ST_RESP;
                        end else begin
                            cnt   <= WAIT_CNT_W'(WAIT_CYCLES);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= lat_we ? '0 : lane_rdata(lat_size, lat_addr[1:0], bank_rdata);
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        v_valid;
    logic        v_we;
    logic [13:0] v_addr;
    logic [1:0]  v_size;
    logic [31:0] v_wdata;

    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(14)) bus0 ();
    dmem_responder_if #(.ADDR_W(14)) bus1 ();

    assign bus0.req_valid = v_valid & ~sel;
    assign bus0.req_we    = v_we;
    assign bus0.req_addr  = v_addr;
    assign bus0.req_size  = v_size;
    assign bus0.req_wdata = v_wdata;
    assign bus1.req_valid = v_valid & sel;
    assign bus1.req_we    = v_we;
    assign bus1.req_addr  = v_addr;
    assign bus1.req_size  = v_size;
    assign bus1.req_wdata = v_wdata;

    dmem_responder #(.ADDR_W(14), .WAIT_CYCLES(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dmem_responder #(.ADDR_W(14), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        m_valid, m_ready, m_rsp_valid, m_err, m_stall;
    logic [31:0] m_rdata;
    assign m_valid     = sel ? bus1.req_valid : bus0.req_valid;
    assign m_ready     = sel ? bus1.req_ready : bus0.req_ready;
    assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign m_rdata     = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign m_err       = sel ? bus1.rsp_err   : bus0.rsp_err;
    assign m_stall     = sel ? bus1.stall     : bus0.stall;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_miss  = 0;
    int   next_id = 0;

    always @(posedge clk) cyc++;

    // Monitor: record acceptances, pop and compare on every response pulse.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        int   lat;
        if (!rst) begin
            acc_q.delete();
        end else begin
            if (m_valid && m_ready) acc_q.push_back(cyc);
            if (m_rsp_valid) begin
                n_vec++;
                if (exp_q.size() == 0 || acc_q.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_rsp: rdata=%h err=%b, want no response", m_rdata, m_err);
                end else begin
                    e   = exp_q.pop_front();
                    a   = acc_q.pop_front();
                    lat = cyc - a - 1;
                    if (m_rdata !== e.rdata || m_err !== e.err || lat != e.lat) begin
                        n_miss++;
                        $display("FAIL rsp#%0d: rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                                 e.id, m_rdata, m_err, lat, e.rdata, e.err, e.lat);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, expv);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: timed out, got no event, want one", name);
    endtask

    function automatic void push_exp(input logic [31:0] rd, input logic err);
        exp_t e;
        e.id    = next_id++;
        e.rdata = rd;
        e.err   = err;
        e.lat   = err ? 0 : (sel ? 1 : 3);
        exp_q.push_back(e);
    endfunction

    // Issue one request, wait for acceptance, then wait for the scoreboard to drain.
    task automatic issue(input logic we, input logic [13:0] addr, input logic [1:0] size,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
        int n;
        push_exp(exp_rd, exp_err);
        @(posedge clk); #1;
        v_valid = 1'b1; v_we = we; v_addr = addr; v_size = size; v_wdata = wdata;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_ready && n < 50);
        if (!m_ready) timeout("accept");
        @(posedge clk); #1;
        v_valid = 1'b0; v_addr = 14'h2AAA; v_wdata = 32'h5A5A5A5A;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout("response");
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        n_miss++;
        $display("FAIL watchdog: simulation still running, want finished");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        int n;
        rst = 1'b0; sel = 1'b0;
        v_valid = 1'b0; v_we = 1'b0; v_addr = '0; v_size = 2'b10; v_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", bus0.rsp_valid, 0);
        chk("rst_rsp_rdata", bus0.rsp_rdata, 0);
        chk("rst_rsp_err",   bus0.rsp_err,   0);
        rst = 1'b1;
        #1;
        chk("rst_ready", bus0.req_ready, 1);
        chk("rst_stall", bus0.stall, 0);
        @(posedge clk); #1;
        v_valid = 1'b1;
        #1 chk("idle_stall_follows_valid", bus0.stall, 1);
        v_valid = 1'b0;

        // Word store then load
        issue(1'b1, 14'h010, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0);
        issue(1'b0, 14'h010, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Byte/half lanes
        issue(1'b1, 14'h010, 2'b10, 32'h11223344, 32'h0, 1'b0);
        issue(1'b1, 14'h013, 2'b00, 32'h000000AA, 32'h0, 1'b0);
        issue(1'b0, 14'h010, 2'b10, 32'h0, 32'hAA223344, 1'b0);
        issue(1'b0, 14'h012, 2'b01, 32'h0, 32'h0000AA22, 1'b0);
        issue(1'b0, 14'h011, 2'b00, 32'h0, 32'h00000033, 1'b0);
        issue(1'b0, 14'h010, 2'b01, 32'h0, 32'h00003344, 1'b0);

        // Misaligned and reserved size leave memory untouched
        issue(1'b0, 14'h006, 2'b10, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 14'h011, 2'b01, 32'h0000FFFF, 32'h0, 1'b1);
        issue(1'b0, 14'h010, 2'b10, 32'h0, 32'hAA223344, 1'b0);
        issue(1'b1, 14'h010, 2'b11, 32'h00000000, 32'h0, 1'b1);
        issue(1'b0, 14'h010, 2'b10, 32'h0, 32'hAA223344, 1'b0);

        // Continuous req_valid: ready period, stall shape, address changes in WAIT ignored
        @(posedge clk); #1;
        v_valid = 1'b1; v_we = 1'b0; v_size = 2'b10; v_addr = 14'h010;
        prev = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("stall_hold", m_stall, !m_rsp_valid);
            if (m_ready) begin
                push_exp(32'hAA223344, 1'b0);
                if (prev >= 0) chk("ready_period", cyc - prev, 5);
                prev = cyc;
            end else if (prev >= 0) begin
                if (cyc - prev == 1) v_addr = 14'h006;
                if (cyc - prev == 3) v_addr = 14'h010;
            end
        end
        @(posedge clk); #1;
        v_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            timeout("burst_drain");
            exp_q.delete();
        end

        // Reset in the middle of a store
        issue(1'b1, 14'h020, 2'b10, 32'h12345678, 32'h0, 1'b0);
        issue(1'b0, 14'h020, 2'b10, 32'h0, 32'h12345678, 1'b0);
        @(posedge clk); #1;
        v_valid = 1'b1; v_we = 1'b1; v_addr = 14'h020; v_size = 2'b10; v_wdata = 32'h00000055;
        @(negedge clk);
        chk("midrst_accept_ready", m_ready, 1);
        @(posedge clk); #1;
        v_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus0.rsp_valid, 0);
        chk("midrst_rsp_rdata", bus0.rsp_rdata, 0);
        chk("midrst_rsp_err",   bus0.rsp_err,   0);
        chk("midrst_ready",     bus0.req_ready, 1);
        chk("midrst_stall",     bus0.stall,     0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 14'h020, 2'b10, 32'h0, 32'h12345678, 1'b0);

        // Zero wait states: latency and top-of-memory indexing
        sel = 1'b1;
        issue(1'b1, 14'h3FFC, 2'b10, 32'hCAFEF00D, 32'h0, 1'b0);
        issue(1'b1, 14'h0000, 2'b10, 32'h0BADBEEF, 32'h0, 1'b0);
        issue(1'b0, 14'h3FFC, 2'b10, 32'h0, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 14'h0000, 2'b10, 32'h0, 32'h0BADBEEF, 1'b0);
        issue(1'b0, 14'h3FFE, 2'b01, 32'h0, 32'h0000CAFE, 1'b0);
        issue(1'b0, 14'h3FFD, 2'b10, 32'h0, 32'h0, 1'b1);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder serving load/store requests from the pipeline's memory stage. It sits on the far side of the core's data-memory port and replaces the zero-latency array with a handshaked slave. The slave has a programmable number of wait states, byte/half/word lanes, misalignment detection, and a stall output that the hazard unit uses to freeze the pipeline. Load data is returned lane-shifted and zero-filled; sign extension stays in the writeback load mux.

## Interface
- `ADDR_W`, 14, byte-address width; memory holds 2^(ADDR_W-2) 32-bit words
- `WAIT_CYCLES`, 2, extra wait states per aligned access (0..15)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous and active-low
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted this cycle when high together with `req_valid`
- `req_we` in 1: 1 = store, 0 = load
- `req_addr` in ADDR_W: byte address
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved
- `req_wdata` in 32: store data, right-justified in the low bits
- `rsp_valid` out 1: one-cycle response pulse
- `rsp_rdata` out 32: load data shifted to bit 0, upper bits zero; 0 for stores and errors
- `rsp_err` out 1: misaligned or reserved-size request; qualified by `rsp_valid`
- `stall` out 1: pipeline freeze request

## Operation
- FSM has three states: IDLE, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch we/addr/size/wdata.
  - Error check: size 11, half with addr[0]=1, or word with addr[1:0]≠0. On error go to RESP with err=1; memory is untouched.
  - Otherwise go to WAIT and load the counter with WAIT_CYCLES.
- **WAIT**
  - `req_ready`=0.
  - While cnt≠0, decrement it.
  - When cnt==0, perform the access on this edge, load `rsp_rdata`/`rsp_err`=0, and go to RESP.
- **RESP**
  - `rsp_valid`=1 for exactly one cycle and `req_ready`=0.
  - Return to IDLE on the next edge. A new request is accepted only after that, with no back-to-back acceptance.
- **Lane rules**
  - Word index = addr[ADDR_W-1:2].
  - Byte lane = addr[1:0]. Half lane = addr[1] (bytes 0-1 or 2-3).
  - Stores write only the enabled bytes, taking wdata[7:0] or wdata[15:0] placed in the lane.
  - Loads return the selected lane in `rsp_rdata`[7:0] or [15:0], upper bits zero. A word load returns the full word.
- **Stall**: `stall` = (IDLE & `req_valid`) | WAIT. It is low in RESP so the pipeline advances in the same cycle it samples `rsp_rdata`.
- **Request changes**: `req_*` changes while not ready are ignored. Only the latched copy is used.

## Timing
- **Reset values**: state IDLE, counter 0, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0. `req_ready`=1 and `stall` follows `req_valid` once rst deasserts.
- **Reset mid-operation**: the pending request is dropped, including a store still in WAIT, which must not write. RAM contents are not cleared by reset.
- **Aligned latency**: accepting edge E0. The access happens at edge E0+WAIT_CYCLES+1. `rsp_valid` is high in the cycle after that edge.
- **Error latency**: `rsp_valid`/`rsp_err` are high in the cycle after E0.
- **Throughput**: one aligned request per WAIT_CYCLES+3 cycles; one error request per 2 cycles (IDLE plus one RESP cycle).
- **Output registers**: all outputs except `req_ready` and `stall` are registered. `req_ready`/`stall` are decoded from state plus `req_valid` only.

## Structure
- **Package `dmem_pkg`**: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and `WAIT_CNT_W`=4.
- **Sub-module `dmem_bank`**: synchronous RAM with four byte-lane write enables and a 32-bit registered-address read. Address width is ADDR_W-2.
- **Top level**: contains the FSM, counter, alignment checker, lane shift/mask logic, and response registers.

## Test plan
- **Word store then load** (WAIT_CYCLES=2): store 0xDEADBEEF at addr 0x010, then load 0x010.
  - Store: `rsp_valid` 4 cycles after acceptance, with `rsp_rdata`=0 and err=0.
  - Load: returns 0xDEADBEEF.
- **Byte/half lanes**:
  - Store byte wdata=0x000000AA to 0x013 over word 0x11223344, then load word 0x010: returns 0xAA223344.
  - Load half at 0x012: returns 0x0000AA22.
- **Misaligned**: word load at 0x006 and half store at 0x011.
  - Each returns `rsp_valid`+`rsp_err`=1 one cycle after acceptance.
  - Memory is unchanged, verified by a word read-back.
  - Size 11 behaves the same way.
- **Stall/handshake**: hold `req_valid` high continuously.
  - `req_ready` pulses once per 5 cycles (WAIT_CYCLES=2).
  - `stall` is low only in RESP cycles.
  - `req_addr` changed during WAIT has no effect.
- **Reset mid-store**: assert rst one cycle after accepting a store of 0x55 to 0x020.
  - All outputs go to reset values immediately.
  - A later load of 0x020 returns the old contents.
- **WAIT_CYCLES=0**: word load returns `rsp_valid` 2 cycles after acceptance. Check the last RAM address (0x3FFC) for wrap-free indexing.
